lamp_sqrt_ctrl: RTL and testbench

//  Floating-point front/back end for the square-root significand core (lampFPU bf16 format: 1/8/7).

---
 rtl/lampFPU_pkg.sv | 38 +++
 rtl/lamp_round_rne.sv | 28 ++
 rtl/lamp_sqrt_ctrl.sv | 133 +++++++++++++
 tb/tb_lamp_sqrt_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared constants, state and operand-class types for the lampFPU bf16 square-root controller.
// Included by every file of the sqrt front/back end.
package lampFPU_pkg;

    localparam logic [15:0] SQRT2_Q15 = 16'hB505;
    localparam logic [15:0] QNAN_VAL  = 16'h7FC0;
    localparam logic [15:0] PINF_VAL  = 16'h7F80;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        POST,
        OUT
    } sqrt_ctrl_state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } bf16_class_t;

    // Takes only exponent and fraction; the sign is handled separately by the caller.
    function automatic bf16_class_t bf16_classify(input logic [14:0] mag);
        bf16_class_t cls;
        if (mag[14:7] == 8'hFF) begin
            cls = (mag[6:0] != 7'd0) ? CLS_NAN : CLS_INF;
        end else if (mag[14:7] == 8'h00) begin
            cls = (mag[6:0] != 7'd0) ? CLS_DENORM : CLS_ZERO;
        end else begin
            cls = CLS_NORMAL;
        end
        return cls;
    endfunction

endpackage

// File: rtl/lamp_round_rne.sv
// Round-to-nearest-even of a Q1.15 significand in [1,2) down to 7 fraction bits.
// The integer bit is implicit, so only the 15 fraction bits are passed in.
module lamp_round_rne
    import lampFPU_pkg::*;
(
    input  logic [14:0] mant_frac_i,
    input  logic        sticky_i,
    input  logic [7:0]  exp_i,
    output logic [6:0]  frac_o,
    output logic [7:0]  exp_o
);

    logic       guard;
    logic       sticky_all;
    logic       round_up;
    logic [7:0] frac_inc;

    // A carry out of the fraction means the significand rounded up to 2.0.
    always_comb begin
        guard      = mant_frac_i[7];
        sticky_all = (|mant_frac_i[6:0]) | sticky_i;
        round_up   = guard & (sticky_all | mant_frac_i[8]);
        frac_inc   = {1'b0, mant_frac_i[14:8]} + {7'd0, round_up};
        frac_o     = frac_inc[6:0];
        exp_o      = exp_i + {7'd0, frac_inc[7]};
    end

endmodule

// File: rtl/lamp_sqrt_ctrl.sv
// bf16 square-root controller: unpacks the operand, resolves special values, runs the
// significand core, applies sqrt(2) scaling for odd unbiased exponents, rounds and repacks.
module lamp_sqrt_ctrl
    import lampFPU_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        doSqrt_i,
    input  logic [15:0] op_i,
    input  logic        core_valid_i,
    input  logic [15:0] core_res_i,
    output logic        core_start_o,
    output logic [7:0]  core_s_o,
    output logic        busy_o,
    output logic        valid_o,
    output logic [15:0] res_o,
    output logic        invalid_o
);

    sqrt_ctrl_state_t state_q, state_d;
    logic [7:0]       exp_q, exp_d;
    logic [6:0]       frac_q, frac_d;
    logic [15:0]      core_res_q, core_res_d;
    logic [15:0]      res_q, res_d;
    logic             invalid_q, invalid_d;

    bf16_class_t      op_class;
    logic [31:0]      product;
    logic [8:0]       exp_sum;
    logic [14:0]      mant_frac;
    logic             mul_sticky;
    logic [6:0]       rnd_frac;
    logic [7:0]       rnd_exp;
    logic             unused_bits;

    assign op_class = bf16_classify(op_i[14:0]);

    // Even biased exponent means odd unbiased exponent: fold the leftover factor of 2 in as sqrt(2).
    always_comb begin
        product = core_res_q * SQRT2_Q15;
        exp_sum = {1'b0, exp_q} + (exp_q[0] ? 9'd127 : 9'd126);
        if (exp_q[0]) begin
            mant_frac  = core_res_q[14:0];
            mul_sticky = 1'b0;
        end else begin
            mant_frac  = product[29:15];
            mul_sticky = |product[14:0];
        end
    end

    assign unused_bits = ^{product[31:30], exp_sum[0]};

    lamp_round_rne u_round (
        .mant_frac_i (mant_frac),
        .sticky_i    (mul_sticky),
        .exp_i       (exp_sum[8:1]),
        .frac_o      (rnd_frac),
        .exp_o       (rnd_exp)
    );

    always_comb begin
        state_d    = state_q;
        exp_d      = exp_q;
        frac_d     = frac_q;
        core_res_d = core_res_q;
        res_d      = res_q;
        invalid_d  = invalid_q;
        case (state_q)
            IDLE: begin
                if (doSqrt_i) begin
                    exp_d     = op_i[14:7];
                    frac_d    = op_i[6:0];
                    invalid_d = 1'b0;
                    state_d   = OUT;
                    // NaN wins over sign; zero/denormal keep their sign; any other negative is invalid.
                    if (op_class == CLS_NAN) begin
                        res_d = QNAN_VAL;
                    end else if (op_class == CLS_ZERO || op_class == CLS_DENORM) begin
                        res_d = {op_i[15], 15'd0};
                    end else if (op_i[15]) begin
                        res_d     = QNAN_VAL;
                        invalid_d = 1'b1;
                    end else if (op_class == CLS_INF) begin
                        res_d = PINF_VAL;
                    end else begin
                        state_d = START;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (core_valid_i) begin
                    core_res_d = core_res_i;
                    state_d    = POST;
                end
            end
            POST: begin
                res_d     = {1'b0, rnd_exp, rnd_frac};
                invalid_d = 1'b0;
                state_d   = OUT;
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            exp_q      <= 8'd0;
            frac_q     <= 7'd0;
            core_res_q <= 16'd0;
            res_q      <= 16'd0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            frac_q     <= frac_d;
            core_res_q <= core_res_d;
            res_q      <= res_d;
            invalid_q  <= invalid_d;
        end
    end

    assign busy_o       = (state_q != IDLE);
    assign valid_o      = (state_q == OUT);
    assign core_start_o = (state_q == START);
    assign core_s_o     = (state_q == START || state_q == WAIT || state_q == POST) ?
                          {1'b1, frac_q} : 8'd0;
    assign res_o        = res_q;
    assign invalid_o    = invalid_q;

endmodule

// File: tb/tb_lamp_sqrt_ctrl.sv
// Self-checking bench for lamp_sqrt_ctrl: models the significand core with programmable latency
// and compares against a plain-arithmetic bf16 square-root reference.
module tb_lamp_sqrt_ctrl;

    logic        clk;
    logic        rst;
    logic        doSqrt_i;
    logic [15:0] op_i;
    logic        core_valid_i;
    logic [15:0] core_res_i;
    logic        core_start_o;
    logic [7:0]  core_s_o;
    logic        busy_o;
    logic        valid_o;
    logic [15:0] res_o;
    logic        invalid_o;

    int errors = 0;
    int checks = 0;

    int          core_lat = 1;
    logic        model_valid;
    logic [15:0] model_res;
    logic        model_busy;
    int          model_cnt;
    logic        stray_valid;
    logic [15:0] stray_res;

    typedef struct {
        string       name;
        logic [15:0] op;
        logic [15:0] exp_res;
        logic        exp_inv;
    } vec_t;

    vec_t vecs[$];

    lamp_sqrt_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .doSqrt_i     (doSqrt_i),
        .op_i         (op_i),
        .core_valid_i (core_valid_i),
        .core_res_i   (core_res_i),
        .core_start_o (core_start_o),
        .core_s_o     (core_s_o),
        .busy_o       (busy_o),
        .valid_o      (valid_o),
        .res_o        (res_o),
        .invalid_o    (invalid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact core: floor(sqrt(s/128) * 2^15) = floor(sqrt(s * 2^23)).
    function automatic logic [15:0] coreRef(input logic [7:0] s);
        longint v;
        longint r;
        v = longint'(s) << 23;
        r = longint'($sqrt(real'(v)));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return 16'(r);
    endfunction

    function automatic longint rneShift(input longint x, input int sh);
        longint q;
        longint rem;
        longint half;
        q    = x >> sh;
        rem  = x - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        return q;
    endfunction

    // Returns {invalid, result}.
    function automatic logic [16:0] refSqrt(input logic [15:0] op);
        logic   sgn;
        int     e_b;
        int     f;
        int     e;
        int     re;
        longint m;
        longint q;
        sgn = op[15];
        e_b = int'(op[14:7]);
        f   = int'(op[6:0]);
        if (e_b == 255 && f != 0) return {1'b0, 16'h7FC0};
        if (e_b == 0) return {1'b0, sgn, 15'd0};
        if (sgn) return {1'b1, 16'h7FC0};
        if (e_b == 255) return {1'b0, 16'h7F80};
        e = e_b - 127;
        m = longint'(coreRef(8'(128 + f)));
        if (e % 2 != 0) q = rneShift(m * 46341, 23);
        else            q = rneShift(m, 8);
        re = 127 + (e >>> 1);
        if (q == 256) begin
            re++;
            q = 128;
        end
        return {1'b0, 1'b0, 8'(re), 7'(q - 128)};
    endfunction

    assign core_valid_i = model_valid | stray_valid;
    assign core_res_i   = model_valid ? model_res : stray_res;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_busy  <= 1'b0;
            model_valid <= 1'b0;
            model_cnt   <= 0;
            model_res   <= 16'd0;
        end else begin
            model_valid <= 1'b0;
            if (core_start_o) begin
                model_busy <= 1'b1;
                model_cnt  <= core_lat;
                model_res  <= coreRef(core_s_o);
            end else if (model_busy) begin
                if (model_cnt <= 1) begin
                    model_valid <= 1'b1;
                    model_busy  <= 1'b0;
                end else begin
                    model_cnt <= model_cnt - 1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] op, input int lat,
                                 output logic [15:0] res, output logic inv, output bit got,
                                 output int valid_idx, output int start_idx,
                                 output int cv_idx, output int start_cnt);
        got = 0; res = '0; inv = 1'b0;
        valid_idx = 0; start_idx = 0; cv_idx = 0; start_cnt = 0;
        @(negedge clk);
        core_lat = lat;
        op_i     = op;
        doSqrt_i = 1'b1;
        @(negedge clk);
        doSqrt_i = 1'b0;
        op_i     = 16'($urandom);
        for (int i = 1; i <= 100 && !got; i++) begin
            if (core_start_o) begin
                start_cnt++;
                if (start_idx == 0) start_idx = i;
            end
            if (core_valid_i && cv_idx == 0) cv_idx = i;
            if (valid_o) begin
                got       = 1;
                valid_idx = i;
                res       = res_o;
                inv       = invalid_o;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic runCheck(input string name, input logic [15:0] op, input int lat,
                            input logic [15:0] exp_res, input logic exp_inv);
        logic [15:0] res;
        logic        inv;
        bit          got;
        bit          normal;
        int          valid_idx, start_idx, cv_idx, start_cnt;
        normal = (op[15] == 1'b0) && (op[14:7] != 8'h00) && (op[14:7] != 8'hFF);
        applyStimulus(op, lat, res, inv, got, valid_idx, start_idx, cv_idx, start_cnt);
        checkOutput({name, " completes"}, 32'(got), 32'd1);
        if (got) begin
            checkOutput({name, " res"}, 32'(res), 32'(exp_res));
            checkOutput({name, " invalid"}, 32'(inv), 32'(exp_inv));
            if (normal) begin
                checkOutput({name, " start latency"}, 32'(start_idx), 32'd1);
                checkOutput({name, " start count"}, 32'(start_cnt), 32'd1);
                checkOutput({name, " valid after core"}, 32'(valid_idx - cv_idx), 32'd2);
            end else begin
                checkOutput({name, " special latency"}, 32'(valid_idx), 32'd1);
                checkOutput({name, " special no start"}, 32'(start_cnt), 32'd0);
            end
        end
        @(negedge clk);
        checkOutput({name, " valid width"}, 32'(valid_o), 32'd0);
    endtask

    initial begin
        logic [16:0] ref_val;
        logic [15:0] op;
        logic [15:0] seen_res;
        logic        seen_inv;
        int          vcnt;
        int          scnt;
        int          bcnt;

        vecs.push_back('{"4.0",      16'h4080, 16'h4000, 1'b0});
        vecs.push_back('{"2.0",      16'h4000, 16'h3FB5, 1'b0});
        vecs.push_back('{"1.0",      16'h3F80, 16'h3F80, 1'b0});
        vecs.push_back('{"9.0",      16'h4110, 16'h4040, 1'b0});
        vecs.push_back('{"-1.0",     16'hBF80, 16'h7FC0, 1'b1});
        vecs.push_back('{"+inf",     16'h7F80, 16'h7F80, 1'b0});
        vecs.push_back('{"-inf",     16'hFF80, 16'h7FC0, 1'b1});
        vecs.push_back('{"-0",       16'h8000, 16'h8000, 1'b0});
        vecs.push_back('{"+0",       16'h0000, 16'h0000, 1'b0});
        vecs.push_back('{"denorm",   16'h0001, 16'h0000, 1'b0});
        vecs.push_back('{"qnan",     16'h7FA0, 16'h7FC0, 1'b0});
        vecs.push_back('{"neg nan",  16'hFFC1, 16'h7FC0, 1'b0});

        rst         = 1'b0;
        doSqrt_i    = 1'b0;
        op_i        = 16'd0;
        stray_valid = 1'b0;
        stray_res   = 16'd0;
        repeat (3) @(negedge clk);
        checkOutput("reset outputs",
                    32'({valid_o, busy_o, core_start_o, core_s_o, res_o, invalid_o}), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("idle after reset", 32'({busy_o, valid_o}), 32'd0);

        for (int k = 0; k < vecs.size(); k++) begin
            runCheck(vecs[k].name, vecs[k].op, 1 + (k % 5) * 4, vecs[k].exp_res, vecs[k].exp_inv);
        end

        // Requests during START and WAIT must be dropped, not queued.
        @(negedge clk);
        core_lat = 12;
        op_i     = 16'h4080;
        doSqrt_i = 1'b1;
        @(negedge clk);
        vcnt = 0; scnt = 0; seen_res = '0; seen_inv = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (core_start_o) scnt++;
            if (valid_o) begin
                vcnt++;
                seen_res = res_o;
                seen_inv = invalid_o;
            end
            doSqrt_i = (i == 0 || i == 4);
            op_i     = 16'hBF80;
            @(negedge clk);
        end
        doSqrt_i = 1'b0;
        checkOutput("busy request valid count", 32'(vcnt), 32'd1);
        checkOutput("busy request start count", 32'(scnt), 32'd1);
        checkOutput("busy request res", 32'(seen_res), 32'h4000);
        checkOutput("busy request invalid", 32'(seen_inv), 32'd0);

        // Stray core result while idle.
        stray_res   = 16'h8000;
        stray_valid = 1'b1;
        @(negedge clk);
        stray_valid = 1'b0;
        vcnt = 0; bcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid_o) vcnt++;
            if (busy_o) bcnt++;
            @(negedge clk);
        end
        checkOutput("stray core valid", 32'(vcnt), 32'd0);
        checkOutput("stray core busy", 32'(bcnt), 32'd0);

        // Reset while waiting on the core.
        core_lat = 15;
        op_i     = 16'h4000;
        doSqrt_i = 1'b1;
        @(negedge clk);
        doSqrt_i = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("busy before abort", 32'(busy_o), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort outputs",
                    32'({valid_o, busy_o, core_start_o, core_s_o, res_o, invalid_o}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        vcnt = 0; bcnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (valid_o) vcnt++;
            if (busy_o) bcnt++;
        end
        checkOutput("abort no valid", 32'(vcnt), 32'd0);
        checkOutput("abort idle", 32'(bcnt), 32'd0);
        runCheck("after abort 2.0", 16'h4000, 3, 16'h3FB5, 1'b0);

        for (int n = 0; n < 250; n++) begin
            op = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom_range(0, 127))};
            ref_val = refSqrt(op);
            runCheck($sformatf("rand normal %h", op), op, $urandom_range(1, 20),
                     ref_val[15:0], ref_val[16]);
        end
        for (int n = 0; n < 60; n++) begin
            op = 16'($urandom);
            ref_val = refSqrt(op);
            runCheck($sformatf("rand any %h", op), op, $urandom_range(1, 20),
                     ref_val[15:0], ref_val[16]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
